// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Issues PC-register fetch addresses to instruction memory and
//               queues returned instructions with their PC for decode.
//               Define IFQ_BYPASS_EN to forward an ack straight to decode
//               when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        pc_clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_req_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_inst_mem [DEPTH];
    logic [31:0]      r_pc_mem   [DEPTH];

    logic w_accept;
    logic w_ack_live;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_fifo_nonempty;

    assign w_fifo_nonempty = (r_count != '0);
    assign pc_ready        = (r_state == ST_IDLE) && (r_count < c_DEPTH) && !flush;
    assign w_accept        = pc_valid && pc_ready;
    assign w_ack_live      = (r_state == ST_WAIT) && imem_ack && !flush;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = !w_fifo_nonempty && w_ack_live;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed response consumed by decode in the ack cycle is never stored
    assign w_push = w_ack_live && !(w_bypass && id_ready);
    assign w_pop  = w_fifo_nonempty && id_ready && !flush;

    assign id_valid = w_fifo_nonempty || w_bypass;

    always_comb begin
        id_inst = 32'd0;
        id_pc   = 32'd0;
        if (w_fifo_nonempty) begin
            id_inst = r_inst_mem[r_rd_ptr];
            id_pc   = r_pc_mem[r_rd_ptr];
        end else if (w_bypass) begin
            id_inst = imem_rdata;
            id_pc   = r_req_pc;
        end
    end

    always_ff @(posedge pc_clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 32'd0;
            r_req_pc  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        imem_addr <= {pc_in[31:2], 2'b00};
                        imem_req  <= 1'b1;
                        r_req_pc  <= pc_in;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Ack ends the request whether or not a flush drops its data
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pc_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted
    always_ff @(posedge pc_clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// Testbench for ifetch_queue: test-plan scenarios plus randomized traffic,
// all checked against a queue-based transaction model.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        pc_clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    ifetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .pc_clk     (pc_clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc)
    );

    always #5 pc_clk = ~pc_clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    // Transaction-level model: one optional outstanding fetch plus a queue
    ent_t        mq[$];
    bit          m_pending;
    bit          m_dropping;
    logic [31:0] m_addr;
    logic [31:0] m_req_pc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pending  = 0;
        m_dropping = 0;
        m_addr     = 32'd0;
        m_req_pc   = 32'd0;
    endtask

    // Drive one cycle of inputs, check the DUT mid-cycle, then advance the model
    task automatic step(input logic pv, input logic [31:0] pc, input logic ack,
                        input logic [31:0] rd, input logic fl, input logic rdy);
        bit          e_ready;
        bit          e_byp;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        ent_t        ent;
        @(negedge pc_clk);
        pc_valid   = pv;
        pc_in      = pc;
        imem_ack   = ack;
        imem_rdata = rd;
        flush      = fl;
        id_ready   = rdy;
        #1;
        e_ready = !m_pending && (mq.size() < DEPTH) && !fl;
`ifdef IFQ_BYPASS_EN
        e_byp = (mq.size() == 0) && m_pending && !m_dropping && ack && !fl;
`else
        e_byp = 0;
`endif
        e_valid = (mq.size() > 0) || e_byp;
        e_inst  = 32'd0;
        e_pc    = 32'd0;
        if (mq.size() > 0) begin
            e_inst = mq[0].inst;
            e_pc   = mq[0].pc;
        end else if (e_byp) begin
            e_inst = rd;
            e_pc   = m_req_pc;
        end
        check("pc_ready", {31'd0, pc_ready}, {31'd0, e_ready});
        check("imem_req", {31'd0, imem_req}, {31'd0, m_pending});
        if (m_pending) check("imem_addr", imem_addr, m_addr);
        check("id_valid", {31'd0, id_valid}, {31'd0, e_valid});
        check("id_inst", id_inst, e_inst);
        check("id_pc", id_pc, e_pc);

        if (fl) begin
            mq.delete();
            if (m_pending) begin
                if (ack) begin
                    m_pending  = 0;
                    m_dropping = 0;
                end else begin
                    m_dropping = 1;
                end
            end
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (m_pending && ack) begin
                if (!m_dropping && !(e_byp && rdy)) begin
                    ent.inst = rd;
                    ent.pc   = m_req_pc;
                    mq.push_back(ent);
                end
                m_pending  = 0;
                m_dropping = 0;
            end else if (e_ready && pv) begin
                m_pending = 1;
                m_addr    = {pc[31:2], 2'b00};
                m_req_pc  = pc;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge pc_clk);
        pc_valid = 0;
        flush    = 0;
        imem_ack = 0;
        id_ready = 0;
        rst      = 1;
        #1;
        model_reset();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        #2 rst = 0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset while a request is outstanding
        step(1, 32'h10, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        check("tp_rst_pc_ready", {31'd0, pc_ready}, 32'd1);

        // Single fetch, ack two cycles after request
        step(1, 32'h4, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h8C010000, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("tp_single_inst", id_inst, 32'h8C010000);
        check("tp_single_pc", id_pc, 32'h4);
        step(0, 0, 0, 0, 0, 1);

        // Fill the queue, pop once, then refetch and drain in order
        for (int i = 0; i < 4; i++) begin
            step(1, 32'(i * 4), 0, 0, 0, 0);
            step(0, 0, 1, 32'hA000_0000 + 32'(i), 0, 0);
        end
        step(1, 32'h10, 0, 0, 0, 0);
        check("tp_full_pc_ready", {31'd0, pc_ready}, 32'd0);
        step(1, 32'h10, 0, 0, 0, 1);
        step(1, 32'h10, 0, 0, 0, 0);
        step(0, 0, 1, 32'hA000_0004, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

        // Flush while waiting; late response must vanish
        step(1, 32'h20, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hDEADBEEF, 0, 0);
        step(1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h1234_5678, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("tp_flush_pc", id_pc, 32'h100);
        step(0, 0, 0, 0, 0, 1);

        // Flush coincident with ack, two entries queued
        step(1, 32'h40, 0, 0, 0, 0);
        step(0, 0, 1, 32'h1111_1111, 0, 0);
        step(1, 32'h44, 0, 0, 0, 0);
        step(0, 0, 1, 32'h2222_2222, 0, 0);
        step(1, 32'h48, 0, 0, 0, 0);
        step(0, 0, 1, 32'h3333_3333, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        check("tp_flushack_valid", {31'd0, id_valid}, 32'd0);

        // Misaligned fetch address
        step(1, 32'h7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("tp_misalign_addr", imem_addr, 32'h4);
        step(0, 0, 1, 32'hCAFE_F00D, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("tp_misalign_pc", id_pc, 32'h7);
        step(0, 0, 0, 0, 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7,
                     {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3)),
                     $urandom_range(0, 9) < 4,
                     $urandom,
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Consumer side of the PC register. It accepts fetch addresses from the PC register, issues them to instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small FIFO. Decode drains the FIFO through a valid/ready interface. A redirect (flush) discards all queued and in-flight fetches.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >=2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
pc_clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
pc_in  in  32  fetch address from PC register
pc_valid  in  1  pc_in holds a valid fetch address
pc_ready  out  1  address accepted this cycle; PC register may advance
imem_req  out  1  memory request, held until imem_ack
imem_addr  out  32  request address, word aligned
imem_ack  in  1  memory response valid this cycle
imem_rdata  in  32  instruction word, valid with imem_ack
flush  in  1  redirect/jump taken; discard everything
id_valid  out  1  FIFO head valid toward decode
id_ready  in  1  decode accepts head this cycle
id_inst  out  32  head instruction; 0 when id_valid=0
id_pc  out  32  head PC; 0 when id_valid=0

Behaviour:
- Reset (async, any state): state=IDLE; imem_req=0; imem_addr=0; count=0; rd/wr pointers=0; id_valid=0; id_inst=0; id_pc=0. An in-flight memory request is abandoned; memory must tolerate req dropping.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DRAIN: request outstanding but flushed; the response will be discarded.
- pc_ready = (state==IDLE) && (count<DEPTH) && !flush. Combinational.
- IDLE, pc_valid&&pc_ready at edge: imem_addr <= {pc_in[31:2],2'b00}; imem_req <= 1; stored req_pc <= pc_in; go to WAIT.
- WAIT, imem_ack=1 and no flush: push {imem_rdata, req_pc} into the FIFO; imem_req <= 0; go to IDLE. Space is guaranteed because at most one request is outstanding and pc_ready checked count<DEPTH.
- Flush has priority over push, pop and accept:
  - FIFO cleared at edge (count=0, pointers=0); pc_ready=0 in the flush cycle.
  - IDLE: stay IDLE.
  - WAIT with imem_ack the same cycle: response dropped; imem_req <= 0; go to IDLE.
  - WAIT without ack: go to DRAIN; imem_req stays 1.
  - DRAIN: stay DRAIN.
- DRAIN: imem_req held at 1. On imem_ack: drop data; imem_req <= 0; go to IDLE. New addresses are accepted from IDLE the following cycle.
- Pop: id_valid && id_ready at edge advances rd pointer.
- Simultaneous push and pop: count unchanged.
- Pointers wrap modulo DEPTH.
- Latency without bypass: accept at edge N → imem_req high in cycle N+1. Ack sampled at edge M → id_valid high in cycle M+1.
- Max throughput is 1 fetch per 2 cycles with a zero-wait memory. This is acceptable.
- imem_ack outside WAIT/DRAIN is ignored.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty, state==WAIT, imem_ack=1 and !flush, then id_valid=1 combinationally with id_inst=imem_rdata and id_pc=req_pc in the ack cycle. If id_ready=1 that cycle, the entry is consumed and not written. Otherwise it is pushed as normal.
- Undefined: no combinational path from imem_* to id_*; one extra cycle of latency.

Test Plan:
- Reset mid-WAIT: issue pc_in=0x00000010, assert rst before ack → imem_req=0, id_valid=0, pc_ready=1 in the cycle after rst deasserts.
- Single fetch, ack 2 cycles after req: pc_in=0x00000004, imem_rdata=0x8C010000 → id_valid=1 with id_inst=0x8C010000, id_pc=0x00000004; with IFQ_BYPASS_EN, id_valid asserts in the ack cycle itself.
- Fill with id_ready=0: fetch 0x0,0x4,0x8,0xC → pc_ready=0 after the 4th push; then one pop → pc_ready=1 and 0x10 is fetched. Pop order is 0x0,0x4,0x8,0xC,0x10.
- Flush in WAIT with ack 3 cycles later: response 0xDEADBEEF is discarded, id_valid stays 0, imem_req stays 1 until ack, then the next fetch of 0x00000100 returns with id_pc=0x100.
- Flush coincident with ack and with 2 entries queued → count=0, id_valid=0, state=IDLE next cycle, and the acked data never appears.
- Misaligned pc_in=0x00000007 → imem_addr=0x00000004, id_pc=0x00000007.
